hex_rotate_ctrl: RTL and testbench

Sequencing controller for the four-digit character display path (per-digit 2-bit character select followed by the 7-segment character decoder). It takes a 4-character word as four 2-bit codes and rotates it across HEX3..HEX0. It advances one position per prescaled tick in run mode, or one position per Step rising edge when paused. Its outputs drive the per-digit select codes that feed the character decoders directly.

---
 rtl/hex_rotate_ctrl.sv | 80 ++++++++
 tb/tb_hex_rotate_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hex_rotate_ctrl.sv
// Rotates a 4-character word (2-bit codes) across HEX3..HEX0, one position per
// prescaled tick in run mode or per Step rising edge when paused. Define
// ROT_DIR_EN to add the Dir port (1 = rotate right).
module hex_rotate_ctrl #(
  parameter  int TICK_DIV = 50000000,
  localparam int CW       = $clog2(TICK_DIV)
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Step,
`ifdef ROT_DIR_EN
  input  logic       Dir,
`endif
  input  logic [7:0] Word,
  output logic [7:0] Char,
  output logic [1:0] Offset,
  output logic       Tick,
  output logic       Running
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    offset_q, offset_d;
  logic [7:0]    char_q, char_d;
  logic          tick_q, tick_d;
  logic          running_q, running_d;
  logic          step_q, step_d;
  logic          wrap, step_edge, adv, dec;
  logic [1:0]    idx;

  always_comb begin
    running_d = Run;
    step_d    = Step;
    // Manual steps only count while the registered mode is paused.
    step_edge = Step & ~step_q & ~running_q;
    wrap      = running_q && (cnt_q == CW'(TICK_DIV - 1));
    cnt_d     = '0;
    if (running_q && !wrap) cnt_d = cnt_q + CW'(1);
    adv       = wrap | step_edge;
`ifdef ROT_DIR_EN
    dec       = Dir;
`else
    dec       = 1'b0;
`endif
    offset_d  = offset_q;
    if (adv) offset_d = dec ? offset_q - 2'd1 : offset_q + 2'd1;
    tick_d    = adv;
    // Char is mapped from the next offset so both update in the same cycle.
    char_d    = '0;
    idx       = '0;
    for (int k = 0; k < 4; k++) begin
      idx             = 2'(k) - offset_d;
      char_d[2*k +: 2] = Word[{idx, 1'b0} +: 2];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q     <= '0;
      offset_q  <= '0;
      char_q    <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      step_q    <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      char_q    <= char_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      step_q    <= step_d;
    end
  end

  assign Char    = char_q;
  assign Offset  = offset_q;
  assign Tick    = tick_q;
  assign Running = running_q;

endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// Scoreboard bench for hex_rotate_ctrl: directed scenarios plus random traffic,
// expected outputs from a behavioural model, checked by a separate monitor.
module tb_hex_rotate_ctrl;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1, run = 1'b0, stp = 1'b1, dir = 1'b0;
  logic [7:0] word = 8'hE4;
  logic [7:0] chr;
  logic [1:0] off;
  logic       tick, running;

  hex_rotate_ctrl #(.TICK_DIV(TD)) dut (
    .Clock(clk), .Reset(rst), .Run(run), .Step(stp),
`ifdef ROT_DIR_EN
    .Dir(dir),
`endif
    .Word(word), .Char(chr), .Offset(off), .Tick(tick), .Running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] off;
    logic [7:0] chr;
    logic       tick;
    logic       run;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every output cycle that has an expectation queued.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if ({off, chr, tick, running} !== {e.off, e.chr, e.tick, e.run}) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: got off=%0d char=%h tick=%b run=%b, want off=%0d char=%h tick=%b run=%b",
                 cyc, off, chr, tick, running, e.off, e.chr, e.tick, e.run);
      end
    end
  end

  // Reference model: a display offset, seconds-style phase counter while
  // running, and the last seen Step level.
  int   m_off = 0, m_phase = 0;
  logic m_running = 1'b0, m_last_step = 1'b1;

  function automatic logic [7:0] rotated(input logic [7:0] w, input int o);
    logic [15:0] t;
    t = {w, w} << (2 * o);
    return t[15:8];
  endfunction

  task automatic drive(input logic r, input logic rn, input logic s,
                       input logic [7:0] w, input logic d);
    exp_t e;
    bit   advance;
    @(posedge clk);
    #1;
    rst = r; run = rn; stp = s; word = w; dir = d;
    e.cyc = cyc + 1;
    if (r) begin
      m_off = 0; m_phase = 0; m_running = 1'b0; m_last_step = 1'b1;
      e.chr = 8'h00; e.tick = 1'b0;
    end else begin
      if (m_running) begin
        advance = (m_phase == TD - 1);
        m_phase = (m_phase + 1) % TD;
      end else begin
        advance = s && !m_last_step;
        m_phase = 0;
      end
      if (advance) begin
`ifdef ROT_DIR_EN
        m_off = d ? (m_off + 3) % 4 : (m_off + 1) % 4;
`else
        m_off = (m_off + 1) % 4;
`endif
      end
      m_running   = rn;
      m_last_step = s;
      e.chr  = rotated(w, m_off);
      e.tick = advance;
    end
    e.off = 2'(m_off);
    e.run = m_running;
    q.push_back(e);
  endtask

  initial begin
    logic rr, rn, ss, dd;
    logic [7:0] ww;
    // Reset then idle
    drive(1, 0, 0, 8'hE4, 0);
    drive(1, 0, 0, 8'hE4, 0);
    repeat (2) drive(0, 0, 0, 8'hE4, 0);
    // Free-running rotation through a full wrap
    repeat (20) drive(0, 1, 0, 8'hE4, 0);
    // Paused: Step high 3 cycles, low, high again
    drive(0, 0, 0, 8'hE4, 0);
    repeat (3) drive(0, 0, 1, 8'hE4, 0);
    drive(0, 0, 0, 8'hE4, 0);
    repeat (3) drive(0, 0, 1, 8'hE4, 0);
    // Step held high across reset release
    repeat (2) drive(1, 0, 1, 8'hE4, 0);
    repeat (4) drive(0, 0, 1, 8'hE4, 0);
    drive(0, 0, 0, 8'hE4, 0);
`ifdef ROT_DIR_EN
    drive(0, 0, 1, 8'hE4, 1);
    drive(0, 0, 0, 8'hE4, 1);
    drive(0, 0, 0, 8'hE4, 0);
`endif
    // Partial run period, pause, then restart
    repeat (2) drive(0, 1, 0, 8'hE4, 0);
    drive(0, 0, 0, 8'hE4, 0);
    repeat (10) drive(0, 1, 0, 8'hE4, 0);
    // Reset landing just before a tick
    drive(1, 0, 0, 8'hE4, 0);
    drive(0, 1, 0, 8'hE4, 0);
    repeat (3) drive(0, 1, 0, 8'hE4, 0);
    drive(1, 1, 0, 8'hE4, 0);
    repeat (3) drive(0, 0, 0, 8'hE4, 0);
    // Random traffic
    rn = 1'b0; ww = 8'hE4;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) rn = ~rn;
      ss = $urandom_range(0, 1);
      dd = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) ww = 8'($urandom);
      drive(rr, rn, ss, ww, dd);
    end
    repeat (3) drive(0, 0, 0, ww, 0);
    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
